// File: rtl/noc_packetizer.sv
// noc_packetizer: turns a packet request plus a stream of payload words into
// a HEAD / BODY... / TAIL flit sequence (or one HEAD_TAIL flit for an empty
// packet) on a valid/ready router injection port, and counts sent packets.
// Optional build macro NOC_PKT_SEQ_EN: when defined, an 8-bit sequence
// counter is built and stamped into head flit bits [41:34]; otherwise that
// field is zero and the counter does not exist.
module noc_packetizer #(
    parameter logic [3:0] SRC_X = 4'd0,
    parameter logic [3:0] SRC_Y = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_dest_x,
    input  logic [3:0]  req_dest_y,
    input  logic [3:0]  req_len,
    input  logic        pld_valid,
    output logic        pld_ready,
    input  logic [61:0] pld_data,
    output logic [63:0] flit_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [15:0] pkt_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        LAST = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_BODY      = 2'b00;
    localparam logic [1:0] TYPE_TAIL      = 2'b01;
    localparam logic [1:0] TYPE_HEAD      = 2'b10;
    localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

    state_t      state_q, state_d;
    logic [63:0] flit_q, flit_d;
    logic        valid_q, valid_d;
    logic [3:0]  rem_q, rem_d;
    logic [15:0] pkt_sent_q, pkt_sent_d;
    logic [7:0]  seq_field;
    logic        pld_fire;

`ifdef NOC_PKT_SEQ_EN
    logic [7:0]  seq_q, seq_d;
    assign seq_field = seq_q;
`else
    assign seq_field = 8'd0;
`endif

    // A new request is only taken once the previous packet has fully left.
    assign req_ready = (state_q == IDLE);

    // Payload is pulled only while the output register is free or draining
    // this cycle; held low during reset so no word is consumed then.
    assign pld_ready = !rst && (state_q == SEND) && (!valid_q || ready_in);
    assign pld_fire  = pld_valid && pld_ready;

    assign flit_out  = flit_q;
    assign valid_out = valid_q;
    assign pkt_sent  = pkt_sent_q;

    // Next-state logic: build head on request, body/tail on payload, and
    // hold the output flit untouched while the router applies backpressure.
    always_comb begin
        state_d    = state_q;
        flit_d     = flit_q;
        valid_d    = valid_q;
        rem_d      = rem_q;
        pkt_sent_d = pkt_sent_q;
`ifdef NOC_PKT_SEQ_EN
        seq_d      = seq_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    flit_d  = {(req_len == 4'd0) ? TYPE_HEAD_TAIL : TYPE_HEAD,
                               req_dest_x, req_dest_y, SRC_X, SRC_Y,
                               req_len, seq_field, 34'd0};
                    valid_d = 1'b1;
                    rem_d   = req_len;
                    state_d = (req_len == 4'd0) ? LAST : SEND;
`ifdef NOC_PKT_SEQ_EN
                    seq_d   = seq_q + 8'd1;
`endif
                end
            end
            SEND: begin
                if (pld_fire) begin
                    flit_d  = {(rem_q == 4'd1) ? TYPE_TAIL : TYPE_BODY, pld_data};
                    valid_d = 1'b1;
                    rem_d   = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d = LAST;
                    end
                end else if (valid_q && ready_in) begin
                    valid_d = 1'b0;
                end
            end
            LAST: begin
                if (valid_q && ready_in) begin
                    valid_d    = 1'b0;
                    pkt_sent_d = pkt_sent_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset drops any packet in flight without a tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            flit_q     <= 64'd0;
            valid_q    <= 1'b0;
            rem_q      <= 4'd0;
            pkt_sent_q <= 16'd0;
`ifdef NOC_PKT_SEQ_EN
            seq_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            flit_q     <= flit_d;
            valid_q    <= valid_d;
            rem_q      <= rem_d;
            pkt_sent_q <= pkt_sent_d;
`ifdef NOC_PKT_SEQ_EN
            seq_q      <= seq_d;
`endif
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: scoreboard-based bench for noc_packetizer with
// SRC_X=1, SRC_Y=2. Works with or without NOC_PKT_SEQ_EN defined.
`timescale 1ns/1ps
module tb_noc_packetizer;

    localparam logic [3:0] SRC_X = 4'd1;
    localparam logic [3:0] SRC_Y = 4'd2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dest_x;
    logic [3:0]  req_dest_y;
    logic [3:0]  req_len;
    logic        pld_valid;
    logic        pld_ready;
    logic [61:0] pld_data;
    logic [63:0] flit_out;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] pkt_sent;

    noc_packetizer #(.SRC_X(SRC_X), .SRC_Y(SRC_Y)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest_x (req_dest_x),
        .req_dest_y (req_dest_y),
        .req_len    (req_len),
        .pld_valid  (pld_valid),
        .pld_ready  (pld_ready),
        .pld_data   (pld_data),
        .flit_out   (flit_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .pkt_sent   (pkt_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  m_seq = 8'd0;
    logic [3:0]  m_rem = 4'd0;
    logic [15:0] m_pkt = 16'd0;
    int          flit_count = 0;
    int          bubble_count = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_flit = 64'd0;

    int   ready_pct = 100;
    logic ready_mode = 1'b0;
    logic ready_force = 1'b1;
    logic ready_rand = 1'b1;

    assign ready_in = ready_mode ? ready_rand : ready_force;

    typedef struct {
        logic [3:0] dx;
        logic [3:0] dy;
        logic [3:0] len;
        int         rdy_pct;
        int         gap_pct;
        int         exp_flits;
    } vec_t;

    vec_t vecs[7];

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    endtask

    function automatic logic [63:0] make_head(input logic [3:0] dx, input logic [3:0] dy,
                                              input logic [3:0] len, input logic [7:0] sq);
        logic [1:0] t;
        t = (len == 4'd0) ? 2'b11 : 2'b10;
        return {t, dx, dy, SRC_X, SRC_Y, len, sq, 34'd0};
    endfunction

    function automatic logic [7:0] seq_exp();
`ifdef NOC_PKT_SEQ_EN
        return m_seq;
`else
        return 8'd0;
`endif
    endfunction

    // Random router backpressure, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        ready_rand = ($urandom_range(0, 99) < ready_pct);
    end

    // Scoreboard: pop and compare accepted flits, check stall stability,
    // then push expectations for whatever the DUT is accepting this cycle.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            exp_q.delete();
            m_seq = 8'd0;
            m_rem = 4'd0;
            m_pkt = 16'd0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_output("hold_valid", 64'(valid_out), 64'd1);
                check_output("hold_flit", flit_out, prev_flit);
            end
            if (valid_out && ready_in) begin
                flit_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_flit: got 0x%0h, want no flit at %0t", flit_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check_output("flit", flit_out, e);
                    if (e[63:62] == 2'b01 || e[63:62] == 2'b11) m_pkt = m_pkt + 16'd1;
                end
            end
            if (!valid_out && !req_ready) bubble_count++;
            prev_stall = valid_out && !ready_in;
            prev_flit  = flit_out;
            if (req_valid && req_ready) begin
                exp_q.push_back(make_head(req_dest_x, req_dest_y, req_len, seq_exp()));
                m_rem = req_len;
                m_seq = m_seq + 8'd1;
            end
            if (pld_valid && pld_ready) begin
                exp_q.push_back({(m_rem == 4'd1) ? 2'b01 : 2'b00, pld_data});
                m_rem = m_rem - 4'd1;
            end
        end
    end

    task automatic issue_request(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len);
        bit fired;
        int t;
        fired = 1'b0;
        t = 0;
        req_valid  = 1'b1;
        req_dest_x = dx;
        req_dest_y = dy;
        req_len    = len;
        while (!fired && t < 50) begin
            @(negedge clk);
            fired = req_ready;
            @(posedge clk);
            #1;
            t++;
        end
        check_output("req_accept", 64'(fired), 64'd1);
        req_valid  = 1'b0;
        req_dest_x = 4'($urandom);
        req_dest_y = 4'($urandom);
        req_len    = 4'($urandom);
    endtask

    task automatic feed_payload(input int len, input int drop_idx, input int gap_pct, input bit seq_data);
        for (int k = 0; k < len; k++) begin
            bit          fired;
            int          t;
            int          g;
            logic [63:0] w;
            fired = 1'b0;
            t = 0;
            g = 0;
            if (k == drop_idx) begin
                pld_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            while (g < 4 && $urandom_range(0, 99) < gap_pct) begin
                pld_valid = 1'b0;
                @(posedge clk);
                #1;
                g++;
            end
            w = {$urandom, $urandom};
            pld_data  = seq_data ? 62'(k + 1) : w[61:0];
            pld_valid = 1'b1;
            while (!fired && t < 200) begin
                @(negedge clk);
                fired = pld_ready;
                @(posedge clk);
                #1;
                t++;
            end
            check_output("pld_accept", 64'(fired), 64'd1);
        end
        pld_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_output("return_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len,
                                  input int drop_idx, input int gap_pct, input bit seq_data);
        issue_request(dx, dy, len);
        feed_payload(int'(len), drop_idx, gap_pct, seq_data);
        wait_idle();
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_f;
        int base_b;
        int t;
        int k;
        bit fired;
        logic [63:0] w;

        vecs[0] = '{dx: 4'd5,  dy: 4'd6,  len: 4'd1,  rdy_pct: 100, gap_pct: 0,  exp_flits: 2};
        vecs[1] = '{dx: 4'd15, dy: 4'd15, len: 4'd15, rdy_pct: 100, gap_pct: 0,  exp_flits: 16};
        vecs[2] = '{dx: 4'd0,  dy: 4'd0,  len: 4'd7,  rdy_pct: 50,  gap_pct: 30, exp_flits: 8};
        vecs[3] = '{dx: 4'd2,  dy: 4'd9,  len: 4'd15, rdy_pct: 30,  gap_pct: 20, exp_flits: 16};
        vecs[4] = '{dx: 4'd7,  dy: 4'd1,  len: 4'd0,  rdy_pct: 60,  gap_pct: 0,  exp_flits: 1};
        vecs[5] = '{dx: 4'd4,  dy: 4'd4,  len: 4'd2,  rdy_pct: 20,  gap_pct: 50, exp_flits: 3};
        vecs[6] = '{dx: 4'd1,  dy: 4'd14, len: 4'd9,  rdy_pct: 80,  gap_pct: 10, exp_flits: 10};

        rst = 1'b1;
        req_valid = 1'b0;
        req_dest_x = 4'd0;
        req_dest_y = 4'd0;
        req_len = 4'd0;
        pld_valid = 1'b0;
        pld_data = 62'd0;
        ready_mode = 1'b0;
        ready_force = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_output("rst_valid_out", 64'(valid_out), 64'd0);
        check_output("rst_flit_out", flit_out, 64'd0);
        check_output("rst_pld_ready", 64'(pld_ready), 64'd0);
        check_output("rst_pkt_sent", 64'(pkt_sent), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Empty packet: single HEAD_TAIL flit one cycle after the request
        $display("[TB] len=0 single flit");
        req_valid = 1'b1;
        req_dest_x = 4'd3;
        req_dest_y = 4'd4;
        req_len = 4'd0;
        @(negedge clk);
        check_output("a_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_dest_x = 4'd9;
        req_dest_y = 4'd9;
        req_len = 4'd9;
        @(negedge clk);
        check_output("a_head_latency", 64'(valid_out), 64'd1);
        check_output("a_head_value", flit_out, 64'hCD04_8000_0000_0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("a_valid_clear", 64'(valid_out), 64'd0);
        check_output("a_pkt_sent", 64'(pkt_sent), 64'd1);
        check_output("a_req_ready_after", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // len=3 back-to-back payload: four flits on consecutive cycles
        $display("[TB] len=3 continuous");
        fork
            apply_stimulus(4'd3, 4'd4, 4'd3, -1, 0, 1'b1);
            begin
                int tw;
                tw = 0;
                @(negedge clk);
                while (!valid_out && tw < 20) begin
                    @(negedge clk);
                    tw++;
                end
                check_output("b_first_valid", 64'(valid_out), 64'd1);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check_output("b_consecutive", 64'(valid_out), 64'd1);
                end
                @(negedge clk);
                check_output("b_req_ready", 64'(req_ready), 64'd1);
            end
        join
        check_output("b_pkt_sent", 64'(pkt_sent), 64'(m_pkt));

        // len=2 with router stalled for 5 cycles after the head
        $display("[TB] backpressure stall");
        ready_force = 1'b0;
        issue_request(4'd8, 4'd2, 4'd2);
        pld_valid = 1'b1;
        pld_data = 62'h3FFF_0000_1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("c_stall_pld_ready", 64'(pld_ready), 64'd0);
            check_output("c_stall_valid", 64'(valid_out), 64'd1);
            @(posedge clk);
            #1;
        end
        ready_force = 1'b1;
        feed_payload(2, -1, 0, 1'b0);
        wait_idle();
        check_output("c_pkt_sent", 64'(pkt_sent), 64'(m_pkt));

        // len=4 with payload dropped for one cycle: exactly one bubble
        $display("[TB] payload bubble");
        base_f = flit_count;
        base_b = bubble_count;
        apply_stimulus(4'd6, 4'd11, 4'd4, 1, 0, 1'b0);
        check_output("d_flits", 64'(flit_count - base_f), 64'd5);
        check_output("d_bubbles", 64'(bubble_count - base_b), 64'd1);
        check_output("d_pkt_sent", 64'(pkt_sent), 64'(m_pkt));

        // Table of packets under random backpressure and payload gaps
        $display("[TB] vector table");
        ready_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ready_pct = vecs[i].rdy_pct;
            base_f = flit_count;
            apply_stimulus(vecs[i].dx, vecs[i].dy, vecs[i].len, -1, vecs[i].gap_pct, 1'b0);
            check_output("tbl_flits", 64'(flit_count - base_f), 64'(vecs[i].exp_flits));
            check_output("tbl_pkt_sent", 64'(pkt_sent), 64'(m_pkt));
        end
        ready_mode = 1'b0;
        ready_force = 1'b1;

        // Reset after the second body flit of a len=5 packet
        $display("[TB] reset mid-packet");
        issue_request(4'd5, 4'd5, 4'd5);
        base_f = flit_count;
        k = 0;
        t = 0;
        pld_valid = 1'b1;
        while ((flit_count - base_f) < 3 && t < 50) begin
            w = {$urandom, $urandom};
            pld_data = w[61:0];
            @(negedge clk);
            fired = pld_valid && pld_ready;
            @(posedge clk);
            #1;
            if (fired) k++;
            t++;
        end
        check_output("e_flits_before_rst", 64'(flit_count - base_f), 64'd3);
        rst = 1'b1;
        pld_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("e_valid_after_rst", 64'(valid_out), 64'd0);
        check_output("e_flit_after_rst", flit_out, 64'd0);
        check_output("e_pkt_sent_rst", 64'(pkt_sent), 64'd0);
        check_output("e_pld_ready_rst", 64'(pld_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply_stimulus(4'd12, 4'd13, 4'd0, -1, 0, 1'b0);
        check_output("e_pkt_sent_post", 64'(pkt_sent), 64'd1);

        // 257 empty packets: sequence field walks 0..255 then wraps to 0
        $display("[TB] sequence wrap");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            apply_stimulus(4'(i), 4'(i >> 4), 4'd0, -1, 0, 1'b0);
        end
        check_output("f_pkt_sent", 64'(pkt_sent), 64'd257);
        check_output("f_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
